// File: rtl/clk_en_sched.sv
// Run/halt/single-step clock-enable sequencer: issues a one-cycle tick every div cycles of clk_in.
// Optional LIVE_RECONFIG_EN: ratio accepted outside HALT is queued and takes effect on the next wrap.
module clk_en_sched #(
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 2,
   parameter int TICKS_W     = 32
) (
   input  logic               clk_in,
   input  logic               reset_n,
   input  logic               cfg_valid,
   input  logic [CNT_W-1:0]   cfg_div,
   output logic               cfg_ready,
   input  logic               run_req,
   input  logic               halt_req,
   input  logic               step_req,
   output logic               tick,
   output logic               tick_phase,
   output logic               busy,
   output logic [1:0]         state,
   output logic [TICKS_W-1:0] tick_count
);

   typedef enum logic [1:0] {
      ST_HALT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     div_q, div_d;
   logic                 tick_q, tick_d;
   logic                 phase_q, phase_d;
   logic [TICKS_W-1:0]   count_q, count_d;

   logic                 wrap;
   logic                 cfg_fire;
   logic [CNT_W-1:0]     cfg_val;

   // The wrap edge ends a period; it only exists while the sequencer is active.
   assign wrap     = (state_q != ST_HALT) && (cnt_q == (div_q - ONE));
   assign cfg_fire = cfg_valid && cfg_ready;
   assign cfg_val  = (cfg_div == '0) ? ONE : cfg_div;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_HALT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HALT: begin
            if (halt_req) begin
               state_d = ST_HALT;
            end else if (step_req) begin
               state_d = ST_STEP;
            end else if (run_req) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // A halt landing on the wrap edge needs no drain period.
            if (halt_req && wrap) begin
               state_d = ST_HALT;
            end else if (halt_req) begin
               state_d = ST_DRAIN;
            end
         end
         ST_STEP, ST_DRAIN: begin
            if (wrap) begin
               state_d = ST_HALT;
            end
         end
         default: state_d = ST_HALT;
      endcase
   end

   always_comb begin
      busy  = (state_q != ST_HALT);
      state = state_q;
`ifdef LIVE_RECONFIG_EN
      cfg_ready = 1'b1;
`else
      cfg_ready = (state_q == ST_HALT);
`endif
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_HALT || wrap) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + ONE;
      end
      tick_d  = wrap;
      phase_d = phase_q ^ wrap;
      count_d = count_q + {{(TICKS_W-1){1'b0}}, wrap};
   end

`ifdef LIVE_RECONFIG_EN
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             pend_valid_q, pend_valid_d;

   // HALT accepts apply at once; active-state accepts wait for the period boundary.
   always_comb begin
      div_d        = div_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      if (cfg_fire && state_q == ST_HALT) begin
         div_d        = cfg_val;
         pend_valid_d = 1'b0;
      end else begin
         if (wrap && pend_valid_q) begin
            div_d        = pend_q;
            pend_valid_d = 1'b0;
         end
         if (cfg_fire) begin
            pend_d       = cfg_val;
            pend_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         pend_q       <= DIV_RST;
         pend_valid_q <= 1'b0;
      end else begin
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
      end
   end
`else
   always_comb begin
      div_d = div_q;
      if (cfg_fire) begin
         div_d = cfg_val;
      end
   end
`endif

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         div_q   <= DIV_RST;
         tick_q  <= 1'b0;
         phase_q <= 1'b0;
         count_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         tick_q  <= tick_d;
         phase_q <= phase_d;
         count_q <= count_d;
      end
   end

   assign tick       = tick_q;
   assign tick_phase = phase_q;
   assign tick_count = count_q;

endmodule
